// File: rtl/qracc_pkg.sv
// Shared QR accelerator types: SRAM controller states, control bundle, default timings.
// No logic of its own; zero latency.
// No flow control here; consumers own the handshakes.
package qracc_pkg;

    localparam int SRAM_NUM_ROWS   = 128;
    localparam int SRAM_NUM_COLS   = 32;
    localparam int SRAM_PCH_CYCLES = 1;
    localparam int SRAM_WL_CYCLES  = 2;
    localparam int SRAM_SA_CYCLES  = 1;
    localparam int SRAM_WR_CYCLES  = 2;
    localparam int SRAM_CNT_W      = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PCH,
        S_WR,
        S_WL,
        S_SENSE,
        S_DONE
`ifdef QRACC_SRAM_WRVERIFY_EN
        ,
        S_VPCH,
        S_VWL,
        S_VSENSE
`endif
    } sram_ctrl_state_t;

    typedef struct packed {
        logic pch;
        logic wl;
        logic write;
        logic saen;
        logic rd_vld;
    } sram_ctrl_t;

    // Array signalling that applies for the whole time a state is occupied.
    function automatic sram_ctrl_t sram_ctrl_for(input sram_ctrl_state_t s);
        sram_ctrl_t c;
        c = '0;
        case (s)
            S_PCH:    c.pch = 1'b1;
            S_WR:     begin c.wl = 1'b1; c.write = 1'b1; end
            S_WL:     c.wl = 1'b1;
            S_SENSE:  begin c.wl = 1'b1; c.saen = 1'b1; end
            S_DONE:   c.rd_vld = 1'b1;
`ifdef QRACC_SRAM_WRVERIFY_EN
            S_VPCH:   c.pch = 1'b1;
            S_VWL:    c.wl = 1'b1;
            S_VSENSE: begin c.wl = 1'b1; c.saen = 1'b1; end
`endif
            default:  c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/qracc_wl_decoder.sv
// Row address + enable to one-hot wordline vector.
// Combinational, zero latency.
// No flow control.
module qracc_wl_decoder #(
    parameter int NUM_ROWS = 128,
    parameter int ADDR_W   = $clog2(NUM_ROWS)
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_ROWS-1:0] wl
);

    always_comb begin
        wl = '0;
        if (en) wl[addr] = 1'b1;
    end

endmodule

// File: rtl/qracc_sram_ctrl.sv
// Single-beat SRAM read/write responder sequencing PCH/WL/WRITE/SAEN; optional write-verify via QRACC_SRAM_WRVERIFY_EN.
// Read: rd_valid_o pch+wl+sa cycles after accept; write busy pch+wr cycles (+pch+wl+sa with verify).
// rq_ready_o only in idle with mac_busy_i low; one request in flight, no queueing.
module qracc_sram_ctrl
    import qracc_pkg::*;
#(
    parameter int numRows   = SRAM_NUM_ROWS,
    parameter int numCols   = SRAM_NUM_COLS,
    parameter int pchCycles = SRAM_PCH_CYCLES,
    parameter int wlCycles  = SRAM_WL_CYCLES,
    parameter int saCycles  = SRAM_SA_CYCLES,
    parameter int wrCycles  = SRAM_WR_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rq_valid_i,
    input  logic                       rq_wr_i,
    input  logic [$clog2(numRows)-1:0] addr_i,
    input  logic [numCols-1:0]         wr_data_i,
    output logic                       rq_ready_o,
    output logic                       rd_valid_o,
    output logic [numCols-1:0]         rd_data_o,
    input  logic                       mac_busy_i,
    input  logic [numCols-1:0]         SA_OUT,
    output logic [numRows-1:0]         WL,
    output logic                       PCH,
    output logic                       WRITE,
    output logic                       SAEN,
    output logic [numCols-1:0]         WR_DATA,
    output logic [numCols-1:0]         CSEL,
    output logic                       wr_err_o
);

    localparam int AW = $clog2(numRows);
    localparam int CW = SRAM_CNT_W;

    sram_ctrl_state_t   state;
    logic [CW-1:0]      cnt;
    sram_ctrl_t         ctrl_q;
    logic               is_wr_q;
    logic [AW-1:0]      addr_q;
    logic [numCols-1:0] data_q;
    logic [numCols-1:0] wr_drv_q;
    logic [numCols-1:0] rd_data_q;
    logic               accept;
`ifdef QRACC_SRAM_WRVERIFY_EN
    logic               wr_err_q;
`endif

    assign rq_ready_o = (state == S_IDLE) && !mac_busy_i && !rst;
    assign accept     = rq_valid_i && rq_ready_o;

    // Counter is loaded with (cycles-1) on entry; transitions happen only once it reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ctrl_q    <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_drv_q  <= '0;
            rd_data_q <= '0;
`ifdef QRACC_SRAM_WRVERIFY_EN
            wr_err_q  <= 1'b0;
`endif
        end else if (state != S_IDLE && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_wr_q <= rq_wr_i;
                        addr_q  <= addr_i;
                        data_q  <= wr_data_i;
                        state   <= S_PCH;
                        cnt     <= CW'(pchCycles - 1);
                        ctrl_q  <= sram_ctrl_for(S_PCH);
                    end
                end
                S_PCH: begin
                    if (is_wr_q) begin
                        state    <= S_WR;
                        cnt      <= CW'(wrCycles - 1);
                        ctrl_q   <= sram_ctrl_for(S_WR);
                        wr_drv_q <= data_q;
                    end else begin
                        state  <= S_WL;
                        cnt    <= CW'(wlCycles - 1);
                        ctrl_q <= sram_ctrl_for(S_WL);
                    end
                end
                S_WL: begin
                    state  <= S_SENSE;
                    cnt    <= CW'(saCycles - 1);
                    ctrl_q <= sram_ctrl_for(S_SENSE);
                end
                S_SENSE: begin
                    rd_data_q <= SA_OUT;
                    state     <= S_DONE;
                    cnt       <= '0;
                    ctrl_q    <= sram_ctrl_for(S_DONE);
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    ctrl_q <= '0;
                end
                S_WR: begin
                    wr_drv_q <= '0;
`ifdef QRACC_SRAM_WRVERIFY_EN
                    state    <= S_VPCH;
                    cnt      <= CW'(pchCycles - 1);
                    ctrl_q   <= sram_ctrl_for(S_VPCH);
`else
                    state    <= S_IDLE;
                    ctrl_q   <= '0;
`endif
                end
`ifdef QRACC_SRAM_WRVERIFY_EN
                S_VPCH: begin
                    state  <= S_VWL;
                    cnt    <= CW'(wlCycles - 1);
                    ctrl_q <= sram_ctrl_for(S_VWL);
                end
                S_VWL: begin
                    state  <= S_VSENSE;
                    cnt    <= CW'(saCycles - 1);
                    ctrl_q <= sram_ctrl_for(S_VSENSE);
                end
                S_VSENSE: begin
                    if (SA_OUT != data_q) wr_err_q <= 1'b1;
                    state  <= S_IDLE;
                    ctrl_q <= '0;
                end
`endif
                default: begin
                    state  <= S_IDLE;
                    ctrl_q <= '0;
                end
            endcase
        end
    end

    qracc_wl_decoder #(
        .NUM_ROWS (numRows),
        .ADDR_W   (AW)
    ) u_wl_dec (
        .addr (addr_q),
        .en   (ctrl_q.wl),
        .wl   (WL)
    );

    assign PCH        = ctrl_q.pch;
    assign WRITE      = ctrl_q.write;
    assign SAEN       = ctrl_q.saen;
    assign rd_valid_o = ctrl_q.rd_vld;
    assign rd_data_o  = rd_data_q;
    assign WR_DATA    = wr_drv_q;
    assign CSEL       = {numCols{ctrl_q.wl}};
`ifdef QRACC_SRAM_WRVERIFY_EN
    assign wr_err_o   = wr_err_q;
`else
    assign wr_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_qracc_sram_ctrl.sv
// Scoreboard bench for qracc_sram_ctrl with an emulated bit-cell array and a reference memory.
module tb_qracc_sram_ctrl;
    import qracc_pkg::*;

    localparam int NR  = SRAM_NUM_ROWS;
    localparam int NC  = SRAM_NUM_COLS;
    localparam int AW  = $clog2(NR);
    localparam int P   = SRAM_PCH_CYCLES;
    localparam int WLC = SRAM_WL_CYCLES;
    localparam int SA  = SRAM_SA_CYCLES;
    localparam int WRC = SRAM_WR_CYCLES;
    localparam int RD_LAT = P + WLC + SA;
`ifdef QRACC_SRAM_WRVERIFY_EN
    localparam int WR_OCC = P + WRC + P + WLC + SA;
`else
    localparam int WR_OCC = P + WRC;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rq_valid_i, rq_wr_i, mac_busy_i;
    logic [AW-1:0] addr_i;
    logic [NC-1:0] wr_data_i;
    logic          rq_ready_o, rd_valid_o, PCH, WRITE, SAEN, wr_err_o;
    logic [NC-1:0] rd_data_o, SA_OUT, WR_DATA, CSEL;
    logic [NR-1:0] WL;

    qracc_sram_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rq_valid_i (rq_valid_i),
        .rq_wr_i    (rq_wr_i),
        .addr_i     (addr_i),
        .wr_data_i  (wr_data_i),
        .rq_ready_o (rq_ready_o),
        .rd_valid_o (rd_valid_o),
        .rd_data_o  (rd_data_o),
        .mac_busy_i (mac_busy_i),
        .SA_OUT     (SA_OUT),
        .WL         (WL),
        .PCH        (PCH),
        .WRITE      (WRITE),
        .SAEN       (SAEN),
        .WR_DATA    (WR_DATA),
        .CSEL       (CSEL),
        .wr_err_o   (wr_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Emulated bit-cell array: stores on WRITE, returns the selected row while SAEN is high.
    bit   [NC-1:0] arr [NR];
    logic [NC-1:0] sa_flip;

    function automatic int wl_idx(input logic [NR-1:0] w);
        for (int i = 0; i < NR; i++) if (w[i]) return i;
        return 0;
    endfunction

    always @(posedge clk) if (WRITE) arr[wl_idx(WL)] <= WR_DATA;
    assign SA_OUT = SAEN ? (arr[wl_idx(WL)] ^ sa_flip) : '0;

    // Reference model and scoreboard queues.
    typedef struct {
        logic [NC-1:0] d;
        int            due;
    } rd_exp_t;

    rd_exp_t       rd_q[$];
    int            rdy_q[$];
    bit   [NC-1:0] ref_mem [NR];
    int            last_acc;

    // Monitor: samples after the falling edge once the driver's inputs have settled.
    rd_exp_t       mon_e;
    logic [NC-1:0] last_rd = '0;
    logic          prev_rdy = 1'b1;
    logic          rst_prev = 1'b1;
    logic          ok;

    always begin
        @(negedge clk);
        #2;
        if (rst_prev) begin
            last_rd = '0;
            chk("reset_outputs", {PCH, SAEN, WRITE, rd_valid_o, wr_err_o, |WL, |CSEL, |WR_DATA}, '0);
        end
        if (rst) chk("ready_in_reset", rq_ready_o, 1'b0);
        ok = !((|WL) && PCH) && !(SAEN && !(|WL)) && $onehot0(WL) &&
             (CSEL == ((|WL) ? {NC{1'b1}} : {NC{1'b0}})) && (WRITE || WR_DATA == '0);
`ifndef QRACC_SRAM_WRVERIFY_EN
        ok = ok && !wr_err_o;
`endif
        chk("ctrl_invariants", ok, 1'b1);
        if (rd_valid_o) begin
            if (rd_q.size() == 0) begin
                chk("unexpected_rd_valid", 1'b1, 1'b0);
            end else begin
                mon_e = rd_q.pop_front();
                chk("rd_latency", cyc, mon_e.due);
                chk("rd_data", rd_data_o, mon_e.d);
                last_rd = mon_e.d;
            end
        end else begin
            chk("rd_data_hold", rd_data_o, last_rd);
        end
        if (!rst && !rst_prev && !mac_busy_i && rq_ready_o && !prev_rdy) begin
            if (rdy_q.size() == 0) chk("unexpected_ready", 1'b1, 1'b0);
            else chk("ready_return", cyc, rdy_q.pop_front());
        end
        prev_rdy = rq_ready_o || rst || mac_busy_i;
        rst_prev = rst;
    end

    task automatic do_req(input bit wr, input int a, input logic [NC-1:0] d);
        int      n;
        rd_exp_t e;
        n = 0;
        @(negedge clk);
        rq_valid_i = 1'b1;
        rq_wr_i    = wr;
        addr_i     = AW'(a);
        wr_data_i  = d;
        mac_busy_i = 1'b0;
        #1;
        while (!rq_ready_o && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rq_ready_o) begin
            chk("accept_timeout", 1'b0, 1'b1);
            rq_valid_i = 1'b0;
            return;
        end
        last_acc = cyc + 1;
        if (wr) begin
            ref_mem[a] = d;
            rdy_q.push_back(last_acc + WR_OCC);
        end else begin
            e.d   = ref_mem[a];
            e.due = last_acc + RD_LAT;
            rd_q.push_back(e);
            rdy_q.push_back(last_acc + RD_LAT + 1);
        end
        @(posedge clk);
        #1;
        rq_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rd_q.size() != 0 || rdy_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        chk("drain_empty", rd_q.size() + rdy_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    logic [NR-1:0] ew;
    int            exp_acc;
    bit            rwr;
    int            ra;

    initial begin
        rq_valid_i = 1'b0;
        rq_wr_i    = 1'b0;
        addr_i     = '0;
        wr_data_i  = '0;
        mac_busy_i = 1'b0;
        sa_flip    = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after_reset", rq_ready_o, 1'b1);

        // Directed write: one PCH cycle, then WRC cycles of WL/WRITE/WR_DATA.
        ew = '0;
        ew[5] = 1'b1;
        do_req(1'b1, 5, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("wr_pch_phase", {PCH, |WL, WRITE}, 3'b100);
        for (int i = 0; i < WRC; i++) begin
            @(negedge clk);
            #1;
            chk("wr_wl_row", WL, ew);
            chk("wr_pulse", {WRITE, PCH, WR_DATA}, {1'b1, 1'b0, 32'hDEADBEEF});
        end
        @(negedge clk);
        #1;
        chk("wr_end", {WRITE, |WL}, 2'b00);
        drain();

        // Directed read-back of the same row.
        do_req(1'b0, 5, '0);
        drain();
        repeat (3) @(negedge clk);

        // MAC ownership blocks accepts and array activity.
        @(negedge clk);
        mac_busy_i = 1'b1;
        rq_valid_i = 1'b1;
        rq_wr_i    = 1'b0;
        addr_i     = AW'(5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("mac_block_ready", rq_ready_o, 1'b0);
            chk("mac_block_ctrl", {PCH, SAEN, WRITE, |WL}, 4'b0000);
        end
        exp_acc = cyc + 2;
        do_req(1'b0, 5, '0);
        chk("mac_release_accept", last_acc, exp_acc);
        drain();

        // Reset while the wordline of a read is up.
        do_req(1'b1, 9, 32'hA5A5_0F0F);
        drain();
        do_req(1'b0, 9, '0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_test_in_wl", WL[9], 1'b1);
        rst = 1'b1;
        rd_q.delete();
        rdy_q.delete();
        @(negedge clk);
        #1;
        chk("rst_wl_clear", WL, '0);
        chk("rst_ctrl_clear", {PCH, SAEN, WRITE, rd_valid_o, CSEL, WR_DATA}, '0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        do_req(1'b0, 9, '0);
        drain();

        // Randomized traffic, mostly on a small row window to get read-after-write hits.
        for (int k = 0; k < 40; k++) begin
            rwr = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : int'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_req(rwr, ra, $urandom);
        end
        drain();

`ifdef QRACC_SRAM_WRVERIFY_EN
        chk("wr_err_clean", wr_err_o, 1'b0);
        sa_flip = 32'h0000_0001;
        do_req(1'b1, 7, 32'h0000FFFF);
        drain();
        sa_flip = '0;
        chk("wr_err_set", wr_err_o, 1'b1);
        do_req(1'b1, 8, 32'h1234_5678);
        drain();
        chk("wr_err_sticky", wr_err_o, 1'b1);
        do_req(1'b0, 7, '0);
        drain();
`else
        chk("wr_err_tied", wr_err_o, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
